// File: rtl/srl_fifo_hs_if.sv
// Handshake bundle for srl_fifo_hs: producer write side, consumer read side and
// status outputs. Parameters must match the FIFO instance that uses it.
interface srl_fifo_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 0
);
  localparam int CAP = DEPTH + OUT_REG;
  localparam int CW  = $clog2(CAP + 1);

  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full;

  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  if_almost_empty;
  logic [CW-1:0]         if_num_data_valid;

  // Producer/consumer side of the link.
  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_almost_full, if_dout, if_empty_n, if_almost_empty,
           if_num_data_valid
  );

  // FIFO side of the link.
  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_almost_full, if_dout, if_empty_n, if_almost_empty,
           if_num_data_valid
  );
endinterface

// File: rtl/srl_fifo_hs.sv
// Shift-register FIFO with full_n/empty_n handshakes, occupancy and almost
// flags, and an optional registered first-word-fall-through output stage.
module srl_fifo_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic          clk,
  input logic          reset_n,
  srl_fifo_hs_if.slave bus
);
  localparam int CAP = DEPTH + OUT_REG;
  localparam int CW  = $clog2(CAP + 1);
  localparam int SW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [CW-1:0] CAP_C = CW'(CAP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C  = CW'(AE_LEVEL);

  if (DATA_WIDTH < 1 || DEPTH < 2 || OUT_REG < 0 || OUT_REG > 1 ||
      AF_LEVEL < 1 || AF_LEVEL > CAP || AE_LEVEL < 0 || AE_LEVEL > CAP - 1)
  begin : g_bad_params
    $error("srl_fifo_hs: parameter out of range");
  end

  logic                  wr;
  logic                  rd;
  logic                  srl_pop;
  logic                  v_next;
  logic [DATA_WIDTH-1:0] srl_head;

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [SW-1:0]         srl_cnt_q, srl_cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;

  // Requests while the matching flag is low are dropped with no side effect.
  assign wr = bus.if_write & bus.if_write_ce & full_n_q;
  assign rd = bus.if_read  & bus.if_read_ce  & empty_n_q;

  assign srl_head = srl_q[addr_q];

  // NOTE: storage has no reset so it maps onto SRL primitives; validity is
  // tracked entirely by srl_cnt_q, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr) begin
      srl_q[0] <= bus.if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  v_q, v_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Refill the output register whenever it is empty or being consumed.
    always_comb begin
      v_d     = v_q;
      dout_d  = dout_q;
      srl_pop = 1'b0;
      if (srl_cnt_q != '0 && (!v_q || rd)) begin
        dout_d  = srl_head;
        v_d     = 1'b1;
        srl_pop = 1'b1;
      end else if (rd) begin
        v_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v_q    <= 1'b0;
        dout_q <= '0;
      end else begin
        v_q    <= v_d;
        dout_q <= dout_d;
      end
    end

    assign v_next      = v_d;
    assign bus.if_dout = dout_q;
  end else begin : g_comb_out
    assign srl_pop     = rd;
    assign v_next      = 1'b0;
    assign bus.if_dout = srl_head;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    srl_cnt_d = srl_cnt_q;
    case ({wr, srl_pop})
      2'b10:   srl_cnt_d = srl_cnt_q + SW'(1);
      2'b01:   srl_cnt_d = srl_cnt_q - SW'(1);
      default: srl_cnt_d = srl_cnt_q;
    endcase

    count_d = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Oldest word lives at srl_cnt-1; hold 0 when the SRL is empty.
    addr_d    = (srl_cnt_d == '0) ? '0 : AW'(srl_cnt_d - SW'(1));
    full_n_d  = (count_d < CAP_C);
    empty_n_d = (OUT_REG != 0) ? v_next : (count_d != '0);
    af_d      = (count_d >= AF_C);
    ae_d      = (count_d <= AE_C);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      srl_cnt_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= (AF_LEVEL == 0);
      ae_q      <= 1'b1;
    end else begin
      srl_cnt_q <= srl_cnt_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  assign bus.if_full_n         = full_n_q;
  assign bus.if_empty_n        = empty_n_q;
  assign bus.if_almost_full    = af_q;
  assign bus.if_almost_empty   = ae_q;
  assign bus.if_num_data_valid = count_q;
endmodule

// File: tb/tb_srl_fifo_hs.sv
// Bench for srl_fifo_hs: three configurations share one stimulus stream and are
// compared every cycle against a queue model, plus hand-computed checkpoints.
module tb_srl_fifo_hs;
  localparam int N = 3;
  // Configurations: A = DEPTH 4 comb, B = DEPTH 4 registered, C = DEPTH 8 comb.
  localparam int CAP_M [N] = '{4, 5, 8};
  localparam int OREG_M[N] = '{0, 1, 0};
  localparam int AF_M  [N] = '{3, 3, 6};
  localparam int AE_M  [N] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write = 1'b0, write_ce = 1'b0, read = 1'b0, read_ce = 1'b0;
  logic [7:0] din = '0;
  int         n_tests = 0, n_fail = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  srl_fifo_hs_if #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(0)) a_if ();
  srl_fifo_hs_if #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(1)) b_if ();
  srl_fifo_hs_if #(.DATA_WIDTH(8), .DEPTH(8), .OUT_REG(0)) c_if ();

  assign a_if.if_write = write;  assign a_if.if_write_ce = write_ce;  assign a_if.if_din = din;
  assign a_if.if_read  = read;   assign a_if.if_read_ce  = read_ce;
  assign b_if.if_write = write;  assign b_if.if_write_ce = write_ce;  assign b_if.if_din = din;
  assign b_if.if_read  = read;   assign b_if.if_read_ce  = read_ce;
  assign c_if.if_write = write;  assign c_if.if_write_ce = write_ce;  assign c_if.if_din = din;
  assign c_if.if_read  = read;   assign c_if.if_read_ce  = read_ce;

  srl_fifo_hs #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  srl_fifo_hs #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave));
  srl_fifo_hs #(.DATA_WIDTH(8), .DEPTH(8), .OUT_REG(0), .AF_LEVEL(6), .AE_LEVEL(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(c_if.slave));

  logic [7:0] dout_w[N], cnt_w[N];
  logic       full_w[N], empty_w[N], af_w[N], ae_w[N];

  always_comb begin
    dout_w[0] = a_if.if_dout;  cnt_w[0] = 8'(a_if.if_num_data_valid);
    dout_w[1] = b_if.if_dout;  cnt_w[1] = 8'(b_if.if_num_data_valid);
    dout_w[2] = c_if.if_dout;  cnt_w[2] = 8'(c_if.if_num_data_valid);
    full_w[0] = a_if.if_full_n;  empty_w[0] = a_if.if_empty_n;
    full_w[1] = b_if.if_full_n;  empty_w[1] = b_if.if_empty_n;
    full_w[2] = c_if.if_full_n;  empty_w[2] = c_if.if_empty_n;
    af_w[0] = a_if.if_almost_full;  ae_w[0] = a_if.if_almost_empty;
    af_w[1] = b_if.if_almost_full;  ae_w[1] = b_if.if_almost_empty;
    af_w[2] = c_if.if_almost_full;  ae_w[2] = c_if.if_almost_empty;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a circular queue per configuration plus the expected
  // head-valid bit. A registered output can only present a word that was
  // already stored before the current edge.
  logic [7:0] mem [N][16];
  int         head[N], size[N];
  bit         emp_n[N];

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      if (!reset_n) begin
        head[d] = 0; size[d] = 0; emp_n[d] = 1'b0;
      end else begin
        bit m_wr, m_rd;
        int left;
        m_wr = write && write_ce && (size[d] < CAP_M[d]);
        m_rd = read && read_ce && emp_n[d];
        if (m_rd) begin head[d] = (head[d] + 1) % 16; size[d]--; end
        left = size[d];
        if (m_wr) begin mem[d][(head[d] + size[d]) % 16] = din; size[d]++; end
        emp_n[d] = (OREG_M[d] != 0) ? (size[d] > 0 && !(m_wr && left == 0)) : (size[d] > 0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < N; d++) begin
        check($sformatf("count[%0d]", d), int'(cnt_w[d]), size[d]);
        check($sformatf("full_n[%0d]", d), int'(full_w[d]), int'(size[d] < CAP_M[d]));
        check($sformatf("empty_n[%0d]", d), int'(empty_w[d]), int'(emp_n[d]));
        check($sformatf("almost_full[%0d]", d), int'(af_w[d]), int'(size[d] >= AF_M[d]));
        check($sformatf("almost_empty[%0d]", d), int'(ae_w[d]), int'(size[d] <= AE_M[d]));
        if (emp_n[d]) check($sformatf("dout[%0d]", d), int'(dout_w[d]), int'(mem[d][head[d]]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input bit w, input bit r, input logic [7:0] d);
    write = w; write_ce = 1'b1; read = r; read_ce = 1'b1; din = d;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0; write = 1'b0; read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int pw, pr;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset state
    check("rst_count", int'(cnt_w[0]), 0);
    check("rst_full_n", int'(full_w[0]), 1);
    check("rst_empty_n", int'(empty_w[0]), 0);
    check("rst_almost_empty", int'(ae_w[0]), 1);
    check("rst_almost_full", int'(af_w[0]), 0);

    // Fill: A steps 1..4, B shows its first word two edges after the write
    cyc(1, 0, 8'h11);
    check("fill_cnt1", int'(cnt_w[0]), 1);
    check("b_empty_after_1_edge", int'(empty_w[1]), 0);
    cyc(1, 0, 8'h22);
    check("fill_cnt2", int'(cnt_w[0]), 2);
    check("b_empty_after_2_edges", int'(empty_w[1]), 1);
    check("b_first_dout", int'(dout_w[1]), 'h11);
    cyc(1, 0, 8'h33);
    check("fill_cnt3", int'(cnt_w[0]), 3);
    cyc(1, 0, 8'h44);
    check("fill_cnt4", int'(cnt_w[0]), 4);
    check("a_full_after_4", int'(full_w[0]), 0);
    check("b_not_full_after_4", int'(full_w[1]), 1);
    cyc(1, 0, 8'h55);
    check("a_5th_write_ignored", int'(cnt_w[0]), 4);
    check("b_full_after_5", int'(full_w[1]), 0);
    check("b_count_5", int'(cnt_w[1]), 5);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check($sformatf("a_drain_dout%0d", i), int'(dout_w[0]), 'h11 * (i + 1));
      check($sformatf("b_drain_dout%0d", i), int'(dout_w[1]), 'h11 * (i + 1));
      cyc(0, 1, 8'h00);
    end
    check("a_empty_after_drain", int'(empty_w[0]), 0);
    check("b_last_dout", int'(dout_w[1]), 'h55);
    cyc(0, 1, 8'h00);
    check("b_empty_after_drain", int'(empty_w[1]), 0);

    // Clock enables hold off both sides
    write = 1'b1; write_ce = 1'b0; read = 1'b0; read_ce = 1'b1; din = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("write_ce_low", int'(cnt_w[0]), 0);
    end
    cyc(1, 0, 8'h61); cyc(1, 0, 8'h62); cyc(1, 0, 8'h63);
    write = 1'b0; read = 1'b1; read_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("read_ce_low", int'(cnt_w[0]), 3);
    end

    // Reset mid-stream at count 3
    pulse_reset();
    check("midrst_empty_n", int'(empty_w[0]), 0);
    check("midrst_full_n", int'(full_w[0]), 1);
    check("midrst_count", int'(cnt_w[0]), 0);
    check("midrst_b_count", int'(cnt_w[1]), 0);
    cyc(1, 0, 8'h77);
    check("post_rst_dout", int'(dout_w[0]), 'h77);
    cyc(0, 0, 8'h00);
    check("post_rst_b_dout", int'(dout_w[1]), 'h77);
    cyc(0, 1, 8'h00);
    check("post_rst_drained", int'(cnt_w[0]), 0);

    // Simultaneous read+write at empty, at 2, and at full
    cyc(1, 1, 8'h81);
    check("rw_at_empty_a", int'(cnt_w[0]), 1);
    check("rw_at_empty_b", int'(cnt_w[1]), 1);
    cyc(1, 0, 8'h82);
    cyc(1, 1, 8'h83);
    check("rw_at_2_count", int'(cnt_w[0]), 2);
    check("rw_at_2_order", int'(dout_w[0]), 'h82);
    cyc(1, 0, 8'h84);
    cyc(1, 0, 8'h85);
    check("full_again", int'(full_w[0]), 0);
    cyc(1, 1, 8'h86);
    check("rw_at_full_count", int'(cnt_w[0]), 3);
    check("rw_at_full_full_n", int'(full_w[0]), 1);
    check("rw_at_full_dout", int'(dout_w[0]), 'h83);

    // Thresholds on C (AF 6, AE 2)
    pulse_reset();
    check("c_ae_at_0", int'(ae_w[2]), 1);
    for (int n = 1; n <= 6; n++) begin
      cyc(1, 0, 8'(n));
      if (n == 2) check("c_ae_at_2", int'(ae_w[2]), 1);
      if (n == 3) check("c_ae_at_3", int'(ae_w[2]), 0);
      if (n == 5) check("c_af_at_5", int'(af_w[2]), 0);
      if (n == 6) check("c_af_at_6", int'(af_w[2]), 1);
    end
    cyc(0, 1, 8'h00);
    check("c_af_back_to_5", int'(af_w[2]), 0);
    check("c_count_5", int'(cnt_w[2]), 5);

    // Randomised traffic with shifting write/read pressure and rare resets
    pw = 50; pr = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      reset_n  = ($urandom_range(0, 2999) != 0);
      write    = ($urandom_range(0, 99) < pw);
      write_ce = ($urandom_range(0, 7) != 0);
      read     = ($urandom_range(0, 99) < pr);
      read_ce  = ($urandom_range(0, 7) != 0);
      din      = 8'($urandom);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/srl_fifo_hs.md
# srl_fifo_hs

Parametrised shift-register FIFO with ready/valid-style full_n/empty_n handshakes, occupancy reporting, programmable almost-full/almost-empty flags and an optional registered first-word-fall-through output stage. It sits between producer and consumer dataflow processes, such as PE start tokens and packed operand streams in the linear-layer pipeline. It replaces bare SRL storage-plus-external-control pairs with one self-contained block. Storage is a reset-free shift register so synthesis maps it onto SRL primitives.

## Interface
- DATA_WIDTH, 32, word width (≥1)
- DEPTH, 16, shift-register entries (≥2)
- OUT_REG, 0, 0 = combinational read from SRL; 1 = registered FWFT output stage
- AF_LEVEL, DEPTH-1, almost-full threshold, 1..CAP
- AE_LEVEL, 1, almost-empty threshold, 0..CAP-1
- CAP (derived, not overridable) = DEPTH + OUT_REG; CW = clog2(CAP+1)

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- if_write_ce  in  1  write clock enable
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_full_n  out  1  1 = can accept a write
- if_almost_full  out  1  count ≥ AF_LEVEL
- if_read_ce  in  1  read clock enable
- if_read  in  1  read request (pop)
- if_dout  out  DATA_WIDTH  head-of-queue data
- if_empty_n  out  1  1 = if_dout valid
- if_almost_empty  out  1  count ≤ AE_LEVEL
- if_num_data_valid  out  CW  words held, 0..CAP

## Operation
- Write accepted (wr) = if_write & if_write_ce & if_full_n. Read accepted (rd) = if_read & if_read_ce & if_empty_n. Requests while the flag is low are ignored, with no state change.
- On wr: SRL shifts, din enters entry 0. The oldest word sits at entry srl_cnt-1.
- OUT_REG=0:
  - count = srl_cnt.
  - Read address register = srl_cnt-1, clamped at 0.
  - if_dout = SRL[addr], combinational.
- OUT_REG=1:
  - Output register dout_r with valid bit v; count = srl_cnt + v.
  - Load when srl_cnt>0 and (v=0 or rd): dout_r ← SRL[srl_cnt-1], srl_cnt decrements (net of any simultaneous wr), v←1.
  - rd with srl_cnt=0 clears v.
  - No bypass from din to dout_r.
- count update: wr&!rd → +1; rd&!wr → −1; both → unchanged.
- All flags are registered from next-state count:
  - if_full_n = (count_next < CAP)
  - if_empty_n = OUT_REG ? v_next : (count_next > 0)
  - almost flags use the thresholds above.
- Full: if_full_n=0, so simultaneous read and write accepts only the read. if_full_n rises the cycle after that read.
- Empty: simultaneous read and write accepts only the write.
- Count never wraps; it stays within 0..CAP by construction.
- if_dout is undefined while if_empty_n=0; the bench must not check it.

## Timing
- Reset (reset_n=0 at a clk edge):
  - count=0, srl_cnt=0, v=0, addr=0
  - if_full_n=1, if_empty_n=0, if_almost_full=(AF_LEVEL==0 ? 1 : 0)→0, if_almost_empty=1, if_num_data_valid=0
  - dout_r=0 when OUT_REG=1
- SRL contents are not cleared.
- Reset mid-operation discards all data at that edge; the first edge after reset deassertion behaves as empty.
- Write-to-empty_n latency:
  - OUT_REG=0: 1 cycle; empty_n high after the wr edge.
  - OUT_REG=1: 2 cycles; wr edge, then load edge.
- Read: with OUT_REG=0, if_dout changes combinationally after the addr update. With OUT_REG=1, if_dout is a flop output and the next word appears 1 cycle after rd.
- Flag update: 1 cycle after the accepted transaction.
- Throughput: 1 write and 1 read per cycle sustained when 0 < count < CAP.

## Test plan
- Fill/drain, DEPTH=4, OUT_REG=0, DATA_WIDTH=8:
  - Write 0x11,0x22,0x33,0x44 on consecutive cycles. if_full_n drops after the 4th edge, and if_num_data_valid steps 1,2,3,4.
  - A 5th write of 0x55 is ignored.
  - Read 4 words: 0x11..0x44 in order; if_empty_n drops after the 4th read.
- OUT_REG=1, DEPTH=4: CAP=5.
  - A single write into empty raises if_empty_n exactly 2 edges later, with if_dout=written word.
  - Write 5 words and confirm full_n=0 only after the 5th.
- Simultaneous read and write:
  - At count=2: both accepted, count stays 2, order preserved.
  - At full: only the read is accepted and count=CAP-1.
  - At empty: only the write is accepted.
- Thresholds, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2:
  - almost_full asserts when count reaches 6 and deasserts at 5.
  - almost_empty is high at counts 0..2 and low at 3.
- Clock enables: if_write=1 with if_write_ce=0 for 3 cycles gives no count change. The same holds for the read side.
- Reset mid-stream: with count=3, pulse reset_n low for 1 cycle. Next cycle: empty_n=0, full_n=1, num_data_valid=0. The next write then reads back correctly.
- Randomised push/pop (10k cycles, both OUT_REG values) against a scoreboard queue: zero mismatches, and count equal to the model every cycle.
